neuron_mac_unit: RTL and testbench

//  Parametrised fixed-point neuron: accepts D (x, w) operand pairs over a valid/ready stream,

---
 rtl/neuron_mac_unit.sv | 182 ++++++++++++++++++
 tb/tb_neuron_mac_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_unit.sv
// ---------------------------------------------------------------------------
// neuron_mac_unit
//   Fixed-point neuron. Collects D (x, w) operand pairs over a valid/ready
//   input stream and multiply-accumulates them at full precision. It then
//   rescales the sum by 2^-Q (floor), saturates it to N bits and applies the
//   activation selected at start. The result is held behind a valid/ready
//   output.
//
//   Ports
//     clk        clock, all state updates on the rising edge
//     rst        synchronous reset, active-high
//     start      begin an evaluation (only honoured while idle)
//     act_sel    activation: 00 identity, 01 ReLU, 10 step, 11 hard-tanh
//     in_valid   x_in / w_in carry a valid pair
//     in_ready   unit is accepting pairs
//     x_in       input activation, signed QN.Q
//     w_in       weight, signed QN.Q
//     out_valid  out_data carries a result
//     out_ready  consumer takes out_data
//     out_data   activated result, signed QN.Q
//     busy       an evaluation is in progress (not idle)
//     ovf        sticky flag: the last result was saturated
// ---------------------------------------------------------------------------
module neuron_mac_unit #(
  parameter int N = 16,
  parameter int Q = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   act_sel,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] w_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy,
  output logic         ovf
);

  // The accumulator is wide enough for D worst-case products, so it can
  // never wrap.
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int AW = 2 * N + ((D > 1) ? $clog2(D) : 0);

  localparam logic [CW-1:0] LAST_CNT = CW'(D - 1);

  // Saturation bounds, sign-extended to the accumulator width.
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};

  // +1.0 and -1.0 in QN.Q.
  localparam logic [N-1:0]        ONE_U    = N'(1);
  localparam logic signed [N-1:0] ONE_Q    = signed'(ONE_U << Q);
  localparam logic signed [N-1:0] NEG_ONE_Q = -ONE_Q;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACT  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                 state_reg;
  logic signed [AW-1:0]   acc_reg;
  logic [CW-1:0]          cnt_reg;
  logic [1:0]             act_reg;
  logic                   in_ready_reg;
  logic                   out_valid_reg;
  logic                   busy_reg;
  logic                   ovf_reg;
  logic [N-1:0]           out_data_reg;

  logic signed [2*N-1:0]  prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   shifted;
  logic signed [N-1:0]    sat_val;
  logic                   sat_hit;
  logic signed [N-1:0]    act_val;

  // Full-precision product, sign-extended into the accumulator width.
  always_comb begin
    prod     = $signed(x_in) * $signed(w_in);
    prod_ext = AW'(prod);
  end

  // Rescale (arithmetic shift floors toward -inf), saturate, activate.
  always_comb begin
    shifted = acc_reg >>> Q;
    sat_hit = 1'b0;
    sat_val = shifted[N-1:0];
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[N-1:0];
      sat_hit = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[N-1:0];
      sat_hit = 1'b1;
    end

    act_val = sat_val;
    case (act_reg)
      2'b00: act_val = sat_val;
      2'b01: act_val = sat_val[N-1] ? '0 : sat_val;
      2'b10: act_val = (!sat_val[N-1] && (sat_val != '0)) ? ONE_Q : '0;
      default: begin
        // Hard-tanh clamp; deliberately does not touch ovf.
        if (sat_val > ONE_Q)          act_val = ONE_Q;
        else if (sat_val < NEG_ONE_Q) act_val = NEG_ONE_Q;
        else                          act_val = sat_val;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      act_reg       <= 2'b00;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            acc_reg      <= '0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            act_reg      <= act_sel;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b1;
            state_reg    <= ACC;
          end
        end
        ACC: begin
          if (in_valid && in_ready_reg) begin
            acc_reg <= acc_reg + prod_ext;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_CNT) begin
              in_ready_reg <= 1'b0;
              state_reg    <= ACT;
            end
          end
        end
        ACT: begin
          out_data_reg  <= act_val;
          if (sat_hit) ovf_reg <= 1'b1;
          out_valid_reg <= 1'b1;
          state_reg     <= OUT;
        end
        OUT: begin
          // out_data stays put under back-pressure; a start seen in this
          // state (including on the handshake cycle) is dropped.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b0;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign busy      = busy_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_neuron_mac_unit.sv
// ---------------------------------------------------------------------------
// tb_neuron_mac_unit
//   Self-checking bench for neuron_mac_unit (N=16, Q=8, D=4). Inputs are
//   driven and outputs sampled on the falling clock edge. Results are checked
//   against an arithmetic reference model of the neuron.
// ---------------------------------------------------------------------------
module tb_neuron_mac_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  act_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_in;
  logic [15:0] w_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  neuron_mac_unit #(.N(16), .Q(8), .D(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .act_sel   (act_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .w_in      (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: exact integer sum, floor division by 2^Q, clamp, activation.
  function automatic void model(input logic [15:0] xs [4], input logic [15:0] ws [4],
                                input logic [1:0] act, output logic [15:0] r, output logic o);
    longint sum, q, s, a;
    sum = 0;
    for (int i = 0; i < 4; i++)
      sum += longint'($signed(xs[i])) * longint'($signed(ws[i]));
    q = sum / 256;
    if (sum < 0 && (sum % 256) != 0) q = q - 1;
    o = 1'b0;
    s = q;
    if (q > 32767)       begin s = 32767;  o = 1'b1; end
    else if (q < -32768) begin s = -32768; o = 1'b1; end
    case (act)
      2'd0:    a = s;
      2'd1:    a = (s < 0) ? 0 : s;
      2'd2:    a = (s > 0) ? 256 : 0;
      default: a = (s > 256) ? 256 : ((s < -256) ? -256 : s);
    endcase
    r = a[15:0];
  endfunction

  // Stimulus driver: one full evaluation up to the first out_valid cycle.
  task automatic run_eval(input logic [1:0] act, input logic [15:0] xs [4],
                          input logic [15:0] ws [4], input int gap_pct, input bit start_noise,
                          output logic [15:0] res, output logic res_ovf, output int lat,
                          output int accepts, output bit timeout, output logic ovf_at_start);
    int i, cyc;
    timeout = 1'b0;
    start   = 1'b1;
    act_sel = act;
    @(negedge clk);
    start        = 1'b0;
    act_sel      = 2'($urandom);
    ovf_at_start = ovf;
    i   = 0;
    cyc = 0;
    while (i < 4 && cyc < 200) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      x_in     = in_valid ? xs[i] : 16'($urandom);
      w_in     = in_valid ? ws[i] : 16'($urandom);
      if (start_noise) start = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) i++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    accepts  = i;
    if (i < 4) timeout = 1'b1;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) timeout = 1'b1;
    res     = out_data;
    res_ovf = ovf;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; act_sel = 2'b00; in_valid = 1'b0;
    x_in = '0; w_in = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b0)   begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 16'h0)  begin failures++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ovf !== 1'b0)        begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    $display("reset: outputs in_ready=%b out_valid=%b out_data=%h busy=%b ovf=%b", in_ready, out_valid, out_data, busy, ovf);
  endtask

  task automatic test_identity();
    logic [15:0] xs [4], ws [4], res;
    logic ro, os; int lat, acc; bit to;
    xs = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    ws = '{16'h0200, 16'h0200, 16'h0200, 16'h0200};
    run_eval(2'b00, xs, ws, 0, 1'b0, res, ro, lat, acc, to, os);
    checks++; if (to !== 1'b0)      begin failures++; $display("FAIL identity_timeout: got %b expected 0", to); end
    checks++; if (res !== 16'h0800) begin failures++; $display("FAIL identity_data: got %h expected 0800", res); end
    checks++; if (ro !== 1'b0)      begin failures++; $display("FAIL identity_ovf: got %b expected 0", ro); end
    checks++; if (lat !== 2)        begin failures++; $display("FAIL identity_latency: got %0d expected 2", lat); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL identity_in_ready_out: got %b expected 0", in_ready); end
    checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL identity_busy: got %b expected 1", busy); end
    drain();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL identity_out_valid_after: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL identity_busy_after: got %b expected 0", busy); end
    checks++; if (out_data !== 16'h0800) begin failures++; $display("FAIL identity_data_held: got %h expected 0800", out_data); end
    $display("identity: out_data=%h ovf=%b latency=%0d", res, ro, lat);
  endtask

  task automatic test_relu();
    logic [15:0] xs [4], ws [4], res;
    logic ro, os; int lat, acc; bit to;
    xs = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    ws = '{16'hFFA0, 16'hFFA0, 16'hFFA0, 16'hFFA0};   // 4 x -0.375 = -1.5
    run_eval(2'b01, xs, ws, 0, 1'b0, res, ro, lat, acc, to, os);
    drain();
    checks++; if (res !== 16'h0000) begin failures++; $display("FAIL relu_negative: got %h expected 0000", res); end
    $display("relu: sum -1.5 -> out_data=%h", res);
    run_eval(2'b00, xs, ws, 0, 1'b0, res, ro, lat, acc, to, os);
    drain();
    checks++; if (res !== 16'hFE80) begin failures++; $display("FAIL relu_identity_ref: got %h expected fe80", res); end
    $display("identity: sum -1.5 -> out_data=%h", res);
  endtask

  task automatic test_saturation();
    logic [15:0] xs [4], ws [4], res;
    logic ro, os; int lat, acc; bit to;
    xs = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
    ws = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
    run_eval(2'b00, xs, ws, 0, 1'b0, res, ro, lat, acc, to, os);
    drain();
    checks++; if (res !== 16'h7FFF) begin failures++; $display("FAIL sat_data: got %h expected 7fff", res); end
    checks++; if (ro !== 1'b1)      begin failures++; $display("FAIL sat_ovf: got %b expected 1", ro); end
    checks++; if (ovf !== 1'b1)     begin failures++; $display("FAIL sat_ovf_sticky: got %b expected 1", ovf); end
    $display("saturation: out_data=%h ovf=%b", res, ro);
    xs = '{16'h0100, 16'h0000, 16'h0000, 16'h0000};
    ws = '{16'h0100, 16'h0000, 16'h0000, 16'h0000};
    run_eval(2'b00, xs, ws, 0, 1'b0, res, ro, lat, acc, to, os);
    drain();
    checks++; if (os !== 1'b0)      begin failures++; $display("FAIL sat_ovf_cleared_on_start: got %b expected 0", os); end
    checks++; if (res !== 16'h0100) begin failures++; $display("FAIL sat_followup_data: got %h expected 0100", res); end
    $display("saturation follow-up: ovf after start=%b out_data=%h", os, res);
  endtask

  task automatic test_step_tanh();
    logic [15:0] xs [4], ws [4], res;
    logic ro, os; int lat, acc; bit to;
    xs = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    ws = '{16'h0020, 16'h0020, 16'h0020, 16'h0020};   // 0.5
    run_eval(2'b10, xs, ws, 0, 1'b0, res, ro, lat, acc, to, os);
    drain();
    checks++; if (res !== 16'h0100) begin failures++; $display("FAIL step_half: got %h expected 0100", res); end
    $display("step: sum 0.5 -> out_data=%h", res);
    ws = '{16'h00C0, 16'h00C0, 16'h00C0, 16'h00C0};   // 3.0
    run_eval(2'b11, xs, ws, 0, 1'b0, res, ro, lat, acc, to, os);
    drain();
    checks++; if (res !== 16'h0100) begin failures++; $display("FAIL tanh_pos: got %h expected 0100", res); end
    checks++; if (ro !== 1'b0)      begin failures++; $display("FAIL tanh_no_ovf: got %b expected 0", ro); end
    $display("hard-tanh: sum 3.0 -> out_data=%h ovf=%b", res, ro);
    ws = '{16'hFF40, 16'hFF40, 16'hFF40, 16'hFF40};   // -3.0
    run_eval(2'b11, xs, ws, 0, 1'b0, res, ro, lat, acc, to, os);
    drain();
    checks++; if (res !== 16'hFF00) begin failures++; $display("FAIL tanh_neg: got %h expected ff00", res); end
    $display("hard-tanh: sum -3.0 -> out_data=%h", res);
  endtask

  task automatic test_random();
    logic [15:0] xs [4], ws [4], res, exp_r;
    logic ro, exp_o, os; logic [1:0] act; int lat, acc; bit to;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 4; i++) begin
        xs[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
        ws[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
      end
      act = 2'($urandom);
      model(xs, ws, act, exp_r, exp_o);
      run_eval(act, xs, ws, 30, 1'b0, res, ro, lat, acc, to, os);
      drain();
      checks++; if (res !== exp_r) begin failures++; $display("FAIL random_data[%0d]: got %h expected %h", n, res, exp_r); end
      checks++; if (ro !== exp_o)  begin failures++; $display("FAIL random_ovf[%0d]: got %b expected %b", n, ro, exp_o); end
      checks++; if (lat !== 2)     begin failures++; $display("FAIL random_latency[%0d]: got %0d expected 2", n, lat); end
      $display("random[%0d]: act=%0d out_data=%h ovf=%b", n, act, res, ro);
    end
  endtask

  task automatic test_back_pressure();
    logic [15:0] xs [4], ws [4], res, exp_r;
    logic ro, exp_o, os; int lat, acc; bit to;
    for (int i = 0; i < 4; i++) begin
      xs[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
      ws[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
    end
    model(xs, ws, 2'b00, exp_r, exp_o);
    run_eval(2'b00, xs, ws, 50, 1'b1, res, ro, lat, acc, to, os);
    checks++; if (acc !== 4 || to !== 1'b0) begin failures++; $display("FAIL bp_accepts: got %0d timeout=%b expected 4", acc, to); end
    checks++; if (res !== exp_r) begin failures++; $display("FAIL bp_data: got %h expected %h", res, exp_r); end
    // Hold off the consumer with junk on the input side and start pulses.
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'($urandom);
      start    = 1'($urandom);
      x_in     = 16'($urandom);
      w_in     = 16'($urandom);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_r || in_ready !== 1'b0)
        begin failures++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b expected 1 %h 0", c, out_valid, out_data, in_ready, exp_r); end
    end
    in_valid  = 1'b0;
    // A start on the handshake cycle must be dropped.
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_handshake_start: got busy=%b valid=%b expected 0 0", busy, out_valid); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_idle_after: got busy=%b ready=%b expected 0 0", busy, in_ready); end
    $display("back-pressure: accepts=%0d out_data=%h held 5 cycles", acc, res);
  endtask

  task automatic test_reset_mid();
    logic [15:0] xs [4], ws [4], res, exp_r;
    logic ro, exp_o, os; int lat, acc; bit to;
    start = 1'b1; act_sel = 2'b00;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; x_in = 16'h0400; w_in = 16'h0400;
      @(negedge clk);
    end
    rst = 1'b1;   // in_valid still high: reset must win
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0 || busy !== 1'b0 || ovf !== 1'b0)
      begin failures++; $display("FAIL midreset_outputs: got ready=%b valid=%b data=%h busy=%b ovf=%b expected all 0", in_ready, out_valid, out_data, busy, ovf); end
    for (int i = 0; i < 4; i++) begin
      xs[i] = 16'($urandom_range(0, 511)) - 16'd256;
      ws[i] = 16'($urandom_range(0, 511)) - 16'd256;
    end
    model(xs, ws, 2'b00, exp_r, exp_o);
    run_eval(2'b00, xs, ws, 20, 1'b0, res, ro, lat, acc, to, os);
    drain();
    checks++; if (res !== exp_r) begin failures++; $display("FAIL midreset_data: got %h expected %h", res, exp_r); end
    checks++; if (acc !== 4 || lat !== 2) begin failures++; $display("FAIL midreset_accepts: got acc=%0d lat=%0d expected 4 2", acc, lat); end
    $display("reset mid-op: restart out_data=%h", res);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_relu();
    test_saturation();
    test_step_tanh();
    test_random();
    test_back_pressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
